// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile_if
//  Purpose  : Bundle of WB-stage inputs, OF read ports, forwarding tap and
//             commit counter shared between the pipeline and wb_regfile.
//  Revision : 1.0 - initial release
// ============================================================================
interface wb_regfile_if #(
  parameter int CNT_W = 32
);
  // WB-stage instruction and its decoded controls
  logic             stall_WB;
  logic [31:0]      inst_WB;
  logic [31:0]      pc_WB;
  logic             is_Ld_WB;
  logic             isCall_WB;
  logic             isWb_WB;
  logic [4:0]       rd_WB;
  logic [31:0]      aluResult_WB;
  logic [31:0]      DMResult_WB;
  // OF-stage read ports
  logic [3:0]       rs1_addr;
  logic [3:0]       rs2_addr;
  logic [31:0]      rs1_data;
  logic [31:0]      rs2_data;
  // Forwarding tap toward the EX/DM forwarding mux
  logic             fwd_valid;
  logic [3:0]       fwd_rd;
  logic [31:0]      fwd_data;
  // Committed-write counter
  logic [CNT_W-1:0] commit_count;

  // Register file side
  modport slave (
    input  stall_WB, inst_WB, pc_WB, is_Ld_WB, isCall_WB, isWb_WB, rd_WB,
           aluResult_WB, DMResult_WB, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, fwd_valid, fwd_rd, fwd_data, commit_count
  );

  // Pipeline side
  modport master (
    output stall_WB, inst_WB, pc_WB, is_Ld_WB, isCall_WB, isWb_WB, rd_WB,
           aluResult_WB, DMResult_WB, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, fwd_valid, fwd_rd, fwd_data, commit_count
  );
endinterface
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile
//  Purpose  : Writeback value selection, 16x32 architectural register file
//             with two write-bypassed read ports, a zero-latency forwarding
//             tap and a wrapping count of committed register writes.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
  parameter int NUM_REGS = 16,
  parameter int RA_INDEX = 15,
  parameter int CNT_W    = 32
) (
  input  wire logic   clk,
  input  wire logic   rst,
  wb_regfile_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] RA_IDX   = IDX_W'(RA_INDEX);
  localparam logic [4:0]       REG_LIMIT = 5'(NUM_REGS);

  logic [31:0]      regs [NUM_REGS];
  logic [CNT_W-1:0] count_q;

  logic [31:0]      wr_data;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_in_range;
  logic             wr_en;

  // inst_WB is carried for debug visibility only
  logic unused_inst;
  assign unused_inst = ^bus.inst_WB;

  // Writeback select, destination and commit qualifier; reset masks the commit
  always_comb begin
    wr_data     = bus.isCall_WB ? (bus.pc_WB + 32'd4)
                : bus.is_Ld_WB  ? bus.DMResult_WB
                :                 bus.aluResult_WB;
    wr_idx      = bus.isCall_WB ? RA_IDX : bus.rd_WB[IDX_W-1:0];
    rd_in_range = (bus.rd_WB < REG_LIMIT);
    wr_en       = ~rst & ~bus.stall_WB & (bus.isWb_WB | bus.isCall_WB)
                & (bus.isCall_WB | rd_in_range);
  end

  // Register array and commit counter; out-of-range rd simply never commits
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      count_q <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
      count_q      <= count_q + 1'b1;
    end
  end

  // Read ports see a same-cycle commit before it lands in the array
  always_comb begin
    bus.rs1_data = (wr_en && (wr_idx == bus.rs1_addr)) ? wr_data : regs[bus.rs1_addr];
    bus.rs2_data = (wr_en && (wr_idx == bus.rs2_addr)) ? wr_data : regs[bus.rs2_addr];
  end

  // Forwarding tap mirrors the commit presented this cycle
  always_comb begin
    bus.fwd_valid = wr_en;
    bus.fwd_rd    = wr_idx;
    bus.fwd_data  = wr_data;
  end

  assign bus.commit_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_regfile
//  Purpose  : Scoreboard bench for wb_regfile: directed scenarios followed by
//             random WB traffic, checked against an array-based model. A
//             second instance with a 4-bit counter observes counter wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        stall, is_ld, is_call, is_wb;
  logic [31:0] inst, pc, alu, dm;
  logic [4:0]  rd;
  logic [3:0]  a1, a2;

  wb_regfile_if #(.CNT_W(32)) bus_a ();
  wb_regfile_if #(.CNT_W(4))  bus_b ();

  assign bus_a.stall_WB = stall;   assign bus_b.stall_WB = stall;
  assign bus_a.inst_WB = inst;     assign bus_b.inst_WB = inst;
  assign bus_a.pc_WB = pc;         assign bus_b.pc_WB = pc;
  assign bus_a.is_Ld_WB = is_ld;   assign bus_b.is_Ld_WB = is_ld;
  assign bus_a.isCall_WB = is_call; assign bus_b.isCall_WB = is_call;
  assign bus_a.isWb_WB = is_wb;    assign bus_b.isWb_WB = is_wb;
  assign bus_a.rd_WB = rd;         assign bus_b.rd_WB = rd;
  assign bus_a.aluResult_WB = alu; assign bus_b.aluResult_WB = alu;
  assign bus_a.DMResult_WB = dm;   assign bus_b.DMResult_WB = dm;
  assign bus_a.rs1_addr = a1;      assign bus_b.rs1_addr = a1;
  assign bus_a.rs2_addr = a2;      assign bus_b.rs2_addr = a2;

  wb_regfile #(.NUM_REGS(16), .RA_INDEX(15), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  wb_regfile #(.NUM_REGS(16), .RA_INDEX(15), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // Expected outputs for one cycle of stimulus
  typedef struct {
    logic        fv;
    logic [3:0]  frd;
    logic [31:0] fdata;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_regs [16];
  longint unsigned m_cnt = 0;
  int total = 0;
  int bad = 0;
  int pushed = 0;
  int popped = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // One WB cycle: apply inputs, queue the expected response, advance the model
  task automatic drive(input logic r, input logic s, input logic ld, input logic call,
                       input logic wb, input logic [4:0] rdi, input logic [31:0] pci,
                       input logic [31:0] alui, input logic [31:0] dmi,
                       input logic [3:0] x1, input logic [3:0] x2);
    exp_t        e;
    logic        we;
    logic [3:0]  idx;
    logic [31:0] data;
    @(posedge clk);
    #1;
    rst = r; stall = s; is_ld = ld; is_call = call; is_wb = wb; rd = rdi;
    pc = pci; alu = alui; dm = dmi; a1 = x1; a2 = x2; inst = $urandom;
    we   = !r && !s && (wb || call) && (call || (rdi < 5'd16));
    idx  = call ? 4'd15 : rdi[3:0];
    data = call ? pci + 32'd4 : (ld ? dmi : alui);
    e.fv    = we;
    e.frd   = idx;
    e.fdata = data;
    e.r1    = (we && idx == x1) ? data : m_regs[x1];
    e.r2    = (we && idx == x2) ? data : m_regs[x2];
    e.cnt   = m_cnt[31:0];
    e.cnt4  = m_cnt[3:0];
    sb.push_back(e);
    pushed++;
    if (r) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_cnt = 0;
    end else if (we) begin
      m_regs[idx] = data;
      m_cnt++;
    end
  endtask

  task automatic idle_read(input logic [3:0] x1, input logic [3:0] x2);
    drive(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, x1, x2);
  endtask

  // Monitor: on each falling edge compare DUT outputs with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        popped++;
        chk("fwd_valid", {31'd0, bus_a.fwd_valid}, {31'd0, e.fv});
        if (e.fv) begin
          chk("fwd_rd", {28'd0, bus_a.fwd_rd}, {28'd0, e.frd});
          chk("fwd_data", bus_a.fwd_data, e.fdata);
        end
        chk("rs1_data", bus_a.rs1_data, e.r1);
        chk("rs2_data", bus_a.rs2_data, e.r2);
        chk("commit_count", bus_a.commit_count, e.cnt);
        chk("commit_count_w4", {28'd0, bus_b.commit_count}, {28'd0, e.cnt4});
        chk("rs1_data_w4", bus_b.rs1_data, e.r1);
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    rst = 1'b1; stall = 1'b0; is_ld = 1'b0; is_call = 1'b0; is_wb = 1'b0;
    rd = '0; pc = '0; alu = '0; dm = '0; a1 = '0; a2 = '0; inst = '0;
    repeat (2) @(posedge clk);

    // Reset one cycle, then read every register
    drive(1, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0);
    for (int i = 0; i < 16; i++) idle_read(4'(i), 4'(15 - i));

    // ALU writeback with same-cycle bypass on rs1
    drive(0, 0, 0, 0, 1, 5'd3, 32'h100, 32'hDEADBEEF, 32'h0, 4'd3, 4'd0);
    idle_read(4'd3, 4'd3);

    // Stalled load held three cycles, committed on first unstalled cycle
    repeat (3) drive(0, 1, 1, 0, 1, 5'd7, 32'h200, 32'h0, 32'h12345678, 4'd7, 4'd3);
    drive(0, 0, 1, 0, 1, 5'd7, 32'h200, 32'h0, 32'h12345678, 4'd7, 4'd3);
    idle_read(4'd7, 4'd3);

    // Call at top of address space: return address wraps to zero
    drive(0, 0, 0, 0, 1, 5'd2, 32'h300, 32'h55, 32'h0, 4'd2, 4'd15);
    drive(0, 0, 0, 1, 0, 5'd2, 32'hFFFFFFFC, 32'hAA, 32'h0, 4'd15, 4'd2);
    idle_read(4'd15, 4'd2);

    // Out-of-range rd is dropped; reset overrides a simultaneous commit
    drive(0, 0, 0, 0, 1, 5'd20, 32'h0, 32'h77, 32'h0, 4'd4, 4'd0);
    drive(0, 0, 0, 0, 1, 5'd4, 32'h0, 32'h99, 32'h0, 4'd4, 4'd3);
    drive(1, 0, 0, 0, 1, 5'd4, 32'h0, 32'h99, 32'h0, 4'd4, 4'd3);
    idle_read(4'd4, 4'd3);

    // Sixteen commits to r9 with both ports bypassing; 4-bit counter wraps
    for (int i = 0; i < 16; i++)
      drive(0, 0, 0, 0, 1, 5'd9, 32'h0, 32'h1000 + 32'(i), 32'h0, 4'd9, 4'd9);
    idle_read(4'd9, 4'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic       r, s, ld, call, wb;
      logic [4:0] rdi;
      logic [3:0] x1, x2;
      logic [31:0] pci;
      r    = ($urandom_range(0, 39) == 0);
      s    = ($urandom_range(0, 3) == 0);
      ld   = $urandom_range(0, 1) == 1;
      call = ($urandom_range(0, 7) == 0);
      wb   = ($urandom_range(0, 3) != 0);
      rdi  = 5'($urandom_range(0, 19));
      x1   = ($urandom_range(0, 2) == 0) ? rdi[3:0] : 4'($urandom_range(0, 15));
      x2   = ($urandom_range(0, 2) == 0) ? (call ? 4'd15 : rdi[3:0]) : 4'($urandom_range(0, 15));
      pci  = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : $urandom;
      drive(r, s, ld, call, wb, rdi, pci, $urandom, $urandom, x1, x2);
    end
    for (int i = 0; i < 16; i++) idle_read(4'(i), 4'(15 - i));

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(popped), 32'(pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
